// File: rtl/video_src_switch.sv
// Frame-synchronous N-input video source selector: full-frame, horizontal split or blank,
// with control changes committed only at the rising edge of V and one cen-cycle output latency.
module video_src_switch #(
    parameter int                    NUM_SRC = 4,
    parameter int                    DATA_W  = 20,
    parameter int                    PIX_W   = 12,
    parameter logic [DATA_W/2-1:0]   BLANK_Y = 'h040,
    parameter logic [DATA_W/2-1:0]   BLANK_C = 'h200,
    localparam int                   SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cen_i,
    input  logic [NUM_SRC*DATA_W-1:0] vdat_i,
    input  logic [3:0]                fvht_i,
    input  logic [SEL_W-1:0]          sel_a_i,
    input  logic [SEL_W-1:0]          sel_b_i,
    input  logic [1:0]                mode_i,
    input  logic [PIX_W-1:0]          split_col_i,
    output logic [3:0]                fvht_o,
    output logic [DATA_W-1:0]         video_o,
    output logic                      pending_o,
    output logic                      switch_o
);

    localparam logic [PIX_W-1:0] COL_MAX = '1;

    logic [SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [1:0]        mode_q;
    logic [PIX_W-1:0]  split_q;
    logic [PIX_W-1:0]  col_q, col_d;
    logic              prev_v_q;
    logic [DATA_W-1:0] video_q, video_d;
    logic [3:0]        fvht_q;
    logic              switch_q;

    logic              v_rise;
    logic [SEL_W-1:0]  src;
    logic              blank;

    assign v_rise = fvht_i[2] & ~prev_v_q;

    // Source choice uses committed control and the pre-increment column.
    always_comb begin
        src     = ((mode_q == 2'd1) && (col_q >= split_q)) ? sel_b_q : sel_a_q;
        blank   = mode_q[1] | (32'(src) >= NUM_SRC);
        video_d = {BLANK_Y, BLANK_C};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!blank && (src == SEL_W'(k)))
                video_d = vdat_i[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        col_d = col_q;
        if (fvht_i[1])
            col_d = '0;
        else if (col_q != COL_MAX)
            col_d = col_q + 1'b1;
    end

    // In full-frame mode the secondary source and split column do not matter.
    assign pending_o = (mode_i != mode_q) || (sel_a_i != sel_a_q) ||
                       ((mode_i != 2'd0) && ((sel_b_i != sel_b_q) || (split_col_i != split_q)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            mode_q   <= '0;
            split_q  <= '0;
            col_q    <= '0;
            prev_v_q <= 1'b1;
            video_q  <= '0;
            fvht_q   <= '0;
            switch_q <= 1'b0;
        end else begin
            switch_q <= cen_i & v_rise;
            if (cen_i) begin
                video_q  <= video_d;
                fvht_q   <= fvht_i;
                col_q    <= col_d;
                prev_v_q <= fvht_i[2];
                if (v_rise) begin
                    sel_a_q <= sel_a_i;
                    sel_b_q <= sel_b_i;
                    mode_q  <= mode_i;
                    split_q <= split_col_i;
                end
            end
        end
    end

    assign video_o  = video_q;
    assign fvht_o   = fvht_q;
    assign switch_o = switch_q;

endmodule
